// File: rtl/div_pkg.sv
// Shared definitions for the execute-stage divider: FSM encodings, handshake
// levels and the ALU op codes that select DIV/DIVU.
package div_pkg;

   localparam int DIV_DATA_W = 32;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. One quotient bit per
// cycle; result_o = {remainder, quotient}, held while start_i stays high.
module div
   import div_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   localparam int CNT_W  = $clog2(DATA_W + 1);
   localparam int WORK_W = 2*DATA_W + 1;

   function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] x,
                                                input logic              en);
      logic signed [DATA_W-1:0] xs;
      xs = x;
      return en ? -xs : xs;
   endfunction

   function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x,
                                             input logic              is_signed);
      return neg_if(x, is_signed & x[DATA_W-1]);
   endfunction

   div_state_e        state;
   logic [CNT_W-1:0]  cnt;
   logic [WORK_W-1:0] work_p0;
   logic [DATA_W-1:0] divisor_p0;
   logic              neg1_p0, neg2_p0;
   logic [DATA_W-1:0] quot_p1, rem_p1;
   logic [DATA_W:0]   diff;

   // Trial subtraction of the divisor from the upper half of the working register.
   always_comb begin
      diff = {1'b0, work_p0[2*DATA_W-1:DATA_W]} - {1'b0, divisor_p0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= DivFree;
         cnt      <= '0;
         ready_o  <= DivResultNotReady;
         result_o <= '0;
      end else begin
         unique case (state)
            DivFree: begin
               ready_o  <= DivResultNotReady;
               result_o <= '0;
               if (start_i == DivStart && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state <= DivByZero;
                  end else begin
                     state      <= DivOn;
                     cnt        <= '0;
                     neg1_p0    <= signed_div_i & opdata1_i[DATA_W-1];
                     neg2_p0    <= signed_div_i & opdata2_i[DATA_W-1];
                     work_p0    <= {{DATA_W{1'b0}}, mag(opdata1_i, signed_div_i), 1'b0};
                     divisor_p0 <= mag(opdata2_i, signed_div_i);
                  end
               end
            end

            DivByZero: begin
               work_p0 <= '0;
               quot_p1 <= '0;
               rem_p1  <= '0;
               state   <= DivEnd;
            end

            // Stage p0 -> p1: iterate on magnitudes, then restore signs.
            DivOn: begin
               if (annul_i) begin
                  state <= DivFree;
                  cnt   <= '0;
               end else if (cnt != CNT_W'(DATA_W)) begin
                  if (diff[DATA_W])
                     work_p0 <= {work_p0[WORK_W-2:0], 1'b0};
                  else
                     work_p0 <= {diff[DATA_W-1:0], work_p0[DATA_W-1:0], 1'b1};
                  cnt <= cnt + 1'b1;
               end else begin
                  quot_p1 <= neg_if(work_p0[DATA_W-1:0], neg1_p0 ^ neg2_p0);
                  rem_p1  <= neg_if(work_p0[WORK_W-1:DATA_W+1], neg1_p0);
                  cnt     <= '0;
                  state   <= DivEnd;
               end
            end

            // First DivEnd cycle always presents the result, so a start dropped
            // mid-division still yields a one-cycle ready pulse.
            DivEnd: begin
               if (ready_o != DivResultReady) begin
                  result_o <= {rem_p1, quot_p1};
                  ready_o  <= DivResultReady;
               end else if (start_i == DivStop) begin
                  result_o <= '0;
                  ready_o  <= DivResultNotReady;
                  state    <= DivFree;
               end
            end

            default: state <= DivFree;
         endcase
      end
   end

endmodule
